// File: rtl/sdram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : sdram_arbiter
// Purpose  : Multi-channel front end for the SDRAM controller. Grants client
//            requests round-robin, latches the granted request's command,
//            address and write word, presents it on the controller command
//            port, and routes read beats / write completions back to the
//            owning channel only.
// Ports    :
//   clk, reset_n            clock, asynchronous active-low reset
//   ch_command              per-channel 2-bit command (0 idle, 1 write,
//                           2 read, 3 reserved = idle)
//   ch_address              per-channel address
//   ch_data_write           per-channel write word
//   ch_accept               one-cycle pulse: request latched
//   ch_data_read            broadcast read data
//   ch_data_read_valid      read beat valid, owning channel only
//   ch_write_done           write complete, owning channel only
//   ctrl_command            registered command to the controller
//   ctrl_address            latched address
//   ctrl_data_write         latched write word
//   ctrl_ready              controller takes the command this cycle
//   ctrl_data_read          controller read data
//   ctrl_data_read_valid    controller read beat
//   ctrl_data_write_done    controller write complete
// Revision : 1.0 - initial release
// ============================================================================
module sdram_arbiter #(
    parameter int CHANNELS          = 2,
    parameter int ADDRESS_WIDTH     = 22,
    parameter int DATA_WIDTH        = 16,
    parameter int READ_BURST_LENGTH = 4
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic [2*CHANNELS-1:0]          ch_command,
    input  logic [ADDRESS_WIDTH*CHANNELS-1:0] ch_address,
    input  logic [DATA_WIDTH*CHANNELS-1:0] ch_data_write,
    output logic [CHANNELS-1:0]            ch_accept,
    output logic [DATA_WIDTH-1:0]          ch_data_read,
    output logic [CHANNELS-1:0]            ch_data_read_valid,
    output logic [CHANNELS-1:0]            ch_write_done,
    output logic [1:0]                     ctrl_command,
    output logic [ADDRESS_WIDTH-1:0]       ctrl_address,
    output logic [DATA_WIDTH-1:0]          ctrl_data_write,
    input  logic                           ctrl_ready,
    input  logic [DATA_WIDTH-1:0]          ctrl_data_read,
    input  logic                           ctrl_data_read_valid,
    input  logic                           ctrl_data_write_done
);

    localparam int c_grant_w = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int c_beat_w  = $clog2(READ_BURST_LENGTH) + 1;

    localparam logic [1:0] c_cmd_idle  = 2'd0;
    localparam logic [1:0] c_cmd_write = 2'd1;
    localparam logic [1:0] c_cmd_read  = 2'd2;

    localparam logic [c_beat_w-1:0]  c_last_beat  = c_beat_w'(READ_BURST_LENGTH - 1);
    localparam logic [c_grant_w-1:0] c_last_chan  = c_grant_w'(CHANNELS - 1);

    typedef enum logic [1:0] {
        S_IDLE       = 2'd0,
        S_ISSUE      = 2'd1,
        S_WAIT_READ  = 2'd2,
        S_WAIT_WRITE = 2'd3
    } state_t;

    state_t                     r_state;
    logic [c_grant_w-1:0]       r_rr;
    logic [c_grant_w-1:0]       r_grant;
    logic [c_beat_w-1:0]        r_beat;
    logic [CHANNELS-1:0]        r_accept;
    logic [1:0]                 r_ctrl_command;
    logic [ADDRESS_WIDTH-1:0]   r_ctrl_address;
    logic [DATA_WIDTH-1:0]      r_ctrl_data_write;

    logic [CHANNELS-1:0]        w_req;
    logic                       w_pick_found;
    logic [c_grant_w-1:0]       w_pick;
    logic [CHANNELS-1:0]        w_pick_onehot;
    logic [1:0]                 w_pick_cmd;
    logic [ADDRESS_WIDTH-1:0]   w_pick_addr;
    logic [DATA_WIDTH-1:0]      w_pick_data;
    int                         w_best_dist;
    logic [CHANNELS-1:0]        w_grant_onehot;
    logic [c_grant_w-1:0]       w_rr_next;

    // Only write and read count as requests; the reserved code is ignored.
    generate
        for (genvar g = 0; g < CHANNELS; g++) begin : g_req
            assign w_req[g] = (ch_command[2*g +: 2] == c_cmd_write) ||
                              (ch_command[2*g +: 2] == c_cmd_read);
        end
    endgenerate

    // Round-robin pick: the requester with the smallest forward distance
    // from the pointer wins, which gives rr, rr+1, ... wrapping at the top.
    always_comb begin
        w_pick_found  = 1'b0;
        w_pick        = '0;
        w_pick_onehot = '0;
        w_pick_cmd    = c_cmd_idle;
        w_pick_addr   = '0;
        w_pick_data   = '0;
        w_best_dist   = CHANNELS;
        for (int i = 0; i < CHANNELS; i++) begin
            if (w_req[i] && (((i + CHANNELS - int'(r_rr)) % CHANNELS) < w_best_dist)) begin
                w_best_dist      = (i + CHANNELS - int'(r_rr)) % CHANNELS;
                w_pick_found     = 1'b1;
                w_pick           = c_grant_w'(i);
                w_pick_onehot    = '0;
                w_pick_onehot[i] = 1'b1;
                w_pick_cmd       = ch_command[2*i +: 2];
                w_pick_addr      = ch_address[ADDRESS_WIDTH*i +: ADDRESS_WIDTH];
                w_pick_data      = ch_data_write[DATA_WIDTH*i +: DATA_WIDTH];
            end
        end
    end

    always_comb begin
        w_grant_onehot = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            w_grant_onehot[i] = (r_grant == c_grant_w'(i));
        end
    end

    // Pointer moves to the channel after the one just served; with a single
    // channel this is always zero.
    assign w_rr_next = (r_grant == c_last_chan) ? '0 : r_grant + 1'b1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state           <= S_IDLE;
            r_rr              <= '0;
            r_grant           <= '0;
            r_beat            <= '0;
            r_accept          <= '0;
            r_ctrl_command    <= c_cmd_idle;
            r_ctrl_address    <= '0;
            r_ctrl_data_write <= '0;
        end else begin
            // Accept is a single pulse on the first ISSUE cycle.
            r_accept <= '0;
            case (r_state)
                S_IDLE: begin
                    if (w_pick_found) begin
                        r_grant           <= w_pick;
                        r_accept          <= w_pick_onehot;
                        r_ctrl_command    <= w_pick_cmd;
                        r_ctrl_address    <= w_pick_addr;
                        r_ctrl_data_write <= w_pick_data;
                        r_state           <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    // The command register doubles as the latched command
                    // until the controller takes it.
                    if (ctrl_ready) begin
                        r_ctrl_command <= c_cmd_idle;
                        r_beat         <= '0;
                        if (r_ctrl_command == c_cmd_read) begin
                            r_state <= S_WAIT_READ;
                        end else begin
                            r_state <= S_WAIT_WRITE;
                        end
                    end
                end
                S_WAIT_READ: begin
                    if (ctrl_data_read_valid) begin
                        if (r_beat == c_last_beat) begin
                            r_beat  <= '0;
                            r_rr    <= w_rr_next;
                            r_state <= S_IDLE;
                        end else begin
                            r_beat <= r_beat + 1'b1;
                        end
                    end
                end
                S_WAIT_WRITE: begin
                    if (ctrl_data_write_done) begin
                        r_rr    <= w_rr_next;
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Responses are forwarded combinationally, gated by the owning wait state
    // so stray controller responses never reach a client.
    assign ch_data_read       = ctrl_data_read;
    assign ch_data_read_valid = ((r_state == S_WAIT_READ) && ctrl_data_read_valid)
                                ? w_grant_onehot : '0;
    assign ch_write_done      = ((r_state == S_WAIT_WRITE) && ctrl_data_write_done)
                                ? w_grant_onehot : '0;

    assign ch_accept       = r_accept;
    assign ctrl_command    = r_ctrl_command;
    assign ctrl_address    = r_ctrl_address;
    assign ctrl_data_write = r_ctrl_data_write;

endmodule
`default_nettype wire
